// File: rtl/adc_ddr_pkg.sv
// Shared types and AXI constants for the ADC capture-to-DDR burst writer.
// Burst geometry is fixed at 16 beats of 4 bytes.
package adc_ddr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_AW   = 2'd1,
    ST_W    = 2'd2,
    ST_B    = 2'd3
  } wr_state_e;

  localparam int unsigned BURST_BEATS = 16;
  localparam int unsigned BURST_BYTES = 64;

  localparam logic [7:0] AXLEN_BURST = 8'(BURST_BEATS - 1);
  localparam logic [2:0] AXSIZE_4B   = 3'b010;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [3:0] CACHE_BUF   = 4'b0011;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (&v) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/adc_ddr_burst_writer.sv
// Streams ADC sample words into a DDR ring buffer as 16-beat AXI4 INCR bursts.
// Optional burst/stall counters are added when ADC_DDR_BURST_WRITER_STATS_EN is defined.
//
// state   | meaning
// IDLE    | waiting for enable with calibration done
// AW      | presenting burst address, held until accepted
// W       | forwarding 16 stream words onto the write channel
// B       | waiting for the write response, then advance/wrap ring pointer
module adc_ddr_burst_writer
  import adc_ddr_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'hA4000000,
  parameter logic [31:0] RING_BYTES = 32'h04000000
) (
  input  logic        clk,
  input  logic        aresetn,
  input  logic        phy_init_done,
  input  logic        enable,

  input  logic [31:0] s_data,
  input  logic        s_valid,
  output logic        s_ready,

  output logic        m_axi_awid,
  output logic [31:0] m_axi_awaddr,
  output logic [7:0]  m_axi_awlen,
  output logic [2:0]  m_axi_awsize,
  output logic [1:0]  m_axi_awburst,
  output logic        m_axi_awlock,
  output logic [3:0]  m_axi_awcache,
  output logic [2:0]  m_axi_awprot,
  output logic [3:0]  m_axi_awqos,
  output logic        m_axi_awvalid,
  input  logic        m_axi_awready,

  output logic [31:0] m_axi_wdata,
  output logic [3:0]  m_axi_wstrb,
  output logic        m_axi_wlast,
  output logic        m_axi_wvalid,
  input  logic        m_axi_wready,

  input  logic        m_axi_bid,
  input  logic [1:0]  m_axi_bresp,
  input  logic        m_axi_bvalid,
  output logic        m_axi_bready,

  output logic        busy,
  output logic [31:0] wr_addr,
  output logic        wrapped,
  output logic        err
`ifdef ADC_DDR_BURST_WRITER_STATS_EN
  ,
  output logic [31:0] burst_cnt,
  output logic [31:0] stall_cnt
`endif
);

  localparam logic [31:0] BURST_STEP = 32'(BURST_BYTES);
  localparam logic [31:0] RING_END   = BASE_ADDR + RING_BYTES;

  wr_state_e  state;
  logic [3:0] beat_cnt;
  logic       awvalid_q;
  logic       in_w_q;
  logic       bready_q;

  logic run_ok;
  logic aw_hs;
  logic w_hs;
  logic b_hs;
  logic last_beat;
  logic unused_bid;

  assign run_ok     = enable & phy_init_done;
  assign aw_hs      = awvalid_q & m_axi_awready;
  assign w_hs       = in_w_q & s_valid & m_axi_wready;
  assign b_hs       = bready_q & m_axi_bvalid;
  assign last_beat  = (beat_cnt == 4'(BURST_BEATS - 1));
  assign unused_bid = m_axi_bid;

  always_ff @(posedge clk) begin
    if (!aresetn) begin
      state     <= ST_IDLE;
      beat_cnt  <= '0;
      awvalid_q <= 1'b0;
      in_w_q    <= 1'b0;
      bready_q  <= 1'b0;
      wr_addr   <= BASE_ADDR;
      wrapped   <= 1'b0;
      err       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (run_ok) begin
            state     <= ST_AW;
            awvalid_q <= 1'b1;
          end
        end
        ST_AW: begin
          if (aw_hs) begin
            state     <= ST_W;
            awvalid_q <= 1'b0;
            in_w_q    <= 1'b1;
          end
        end
        ST_W: begin
          if (w_hs) begin
            if (last_beat) begin
              state    <= ST_B;
              beat_cnt <= '0;
              in_w_q   <= 1'b0;
              bready_q <= 1'b1;
            end else begin
              beat_cnt <= beat_cnt + 4'd1;
            end
          end
        end
        ST_B: begin
          if (b_hs) begin
            bready_q <= 1'b0;
            if (m_axi_bresp != RESP_OKAY) err <= 1'b1;
            // The ring size is a whole number of bursts, so the end is hit exactly.
            if (wr_addr + BURST_STEP == RING_END) begin
              wr_addr <= BASE_ADDR;
              wrapped <= 1'b1;
            end else begin
              wr_addr <= wr_addr + BURST_STEP;
            end
            if (run_ok) begin
              state     <= ST_AW;
              awvalid_q <= 1'b1;
            end else begin
              state <= ST_IDLE;
            end
          end
        end
        default: begin
          state     <= ST_IDLE;
          awvalid_q <= 1'b0;
          in_w_q    <= 1'b0;
          bready_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy          = (state != ST_IDLE);

  assign m_axi_awid    = 1'b0;
  assign m_axi_awaddr  = wr_addr;
  assign m_axi_awlen   = AXLEN_BURST;
  assign m_axi_awsize  = AXSIZE_4B;
  assign m_axi_awburst = BURST_INCR;
  assign m_axi_awlock  = 1'b0;
  assign m_axi_awcache = CACHE_BUF;
  assign m_axi_awprot  = 3'b000;
  assign m_axi_awqos   = 4'b0000;
  assign m_axi_awvalid = awvalid_q;

  // The write channel is a direct pass-through of the sample stream during W.
  assign m_axi_wdata   = s_data;
  assign m_axi_wstrb   = 4'hF;
  assign m_axi_wvalid  = in_w_q & s_valid;
  assign m_axi_wlast   = in_w_q & last_beat;
  assign s_ready       = in_w_q & m_axi_wready;

  assign m_axi_bready  = bready_q;

`ifdef ADC_DDR_BURST_WRITER_STATS_EN
  always_ff @(posedge clk) begin
    if (!aresetn) begin
      burst_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      if (b_hs) burst_cnt <= sat_inc32(burst_cnt);
      if (in_w_q && s_valid && !m_axi_wready) stall_cnt <= sat_inc32(stall_cnt);
    end
  end
`endif

endmodule

// File: doc/adc_ddr_burst_writer.md
ADC_DDR_BURST_WRITER -- requirements
Module: adc_ddr_burst_writer

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'hA4000000, byte address of capture ring; 64-byte aligned.
REQ-002 SHALL have parameter RING_BYTES, default 32'h04000000, ring size in bytes; multiple of 64.
REQ-003 SHALL have one clock and a synchronous, active-low reset: clk  in  1  sole clock, rising edge; aresetn  in  1  synchronous active-low reset.
REQ-004 phy_init_done  in  1  DDR3 calibration complete; level.
REQ-005 enable  in  1  capture run request; level.
REQ-006 s_data  in  32  sample word; s_valid  in  1; s_ready  out  1  (valid/ready stream).
REQ-007 AXI4 write master, ports m_axi_aw*/w*/b*: awid 1, awaddr 32, awlen 8, awsize 3, awburst 2, awlock 1, awcache 4, awprot 3, awqos 4, awvalid/awready 1; wdata 32, wstrb 4, wlast/wvalid/wready 1; bid 1, bresp 2, bvalid/bready 1.
REQ-008 busy  out  1  FSM not in IDLE; wr_addr  out  32  next burst address; wrapped  out  1  sticky, ring wrapped at least once; err  out  1  sticky, non-OKAY bresp seen.

Function
REQ-009 FSM states SHALL be IDLE, AW, W, B.
REQ-010 IDLE->AW when enable=1 and phy_init_done=1; otherwise stay in IDLE.
REQ-011 AW: awvalid=1, awaddr=wr_addr; on awvalid&awready -> W next cycle; awvalid SHALL stay high until accepted.
REQ-012 Constant AW fields: awlen=15, awsize=3'b010, awburst=2'b01, awid=0, awlock=0, awcache=4'b0011, awprot=0, awqos=0.
REQ-013 W: wvalid=s_valid, s_ready=wready, wdata=s_data, wstrb=4'hF; s_ready=0 in all other states.
REQ-014 4-bit beat counter increments on wvalid&wready; wlast=1 when counter=15; last handshake -> B, counter cleared.
REQ-015 B: bready=1; on bvalid: err set if bresp!=2'b00; wr_addr advances by 64.
REQ-016 Wrap: if wr_addr+64 = BASE_ADDR+RING_BYTES, wr_addr <= BASE_ADDR and wrapped <= 1.
REQ-017 After B: -> AW if enable=1 and phy_init_done=1, else -> IDLE.
REQ-018 enable deassert mid-burst SHALL NOT truncate: the burst completes all 16 beats and its B response.
REQ-019 Bursts SHALL never cross a 4 KB boundary; guaranteed by the alignment rules in REQ-001/002.
REQ-020 AW-to-first-W latency: the first beat may be transferred in the cycle after the AW handshake.
REQ-021 bresp error does not stop capture; err remains set until reset.

Reset
REQ-022 On aresetn=0 at a clk edge: state=IDLE, wr_addr=BASE_ADDR, beat counter=0, wrapped=0, err=0, awvalid=wvalid=bready=s_ready=0.
REQ-023 Reset mid-burst SHALL abandon the transaction without completion; the DDR3 controller shares aresetn, so no AXI recovery is needed.

Configuration
REQ-024 Macro ADC_DDR_BURST_WRITER_STATS_EN defined: adds outputs burst_cnt (32) and stall_cnt (32). burst_cnt counts B handshakes. stall_cnt counts W-state cycles with s_valid=1 and wready=0. Both counters clear on reset and saturate at all-ones.
REQ-025 Macro undefined: the ports and counters SHALL be absent; all other behaviour is identical.

Structure
REQ-026 Shared package adc_ddr_pkg SHALL hold: the state enum, BURST_BEATS=16, BURST_BYTES=64, and the AXI constants (AXSIZE_4B, BURST_INCR, RESP_OKAY, CACHE_BUF).
REQ-027 Single module, no sub-modules; the FSM, counter and address logic are small enough to keep flat.

Verification
REQ-028 phy_init_done=0, enable=1, s_valid=1 for 100 cycles -> awvalid stays 0, s_ready stays 0, busy=0.
REQ-029 Calibration up, 32 words 0..31 streamed, slave always ready -> 2 bursts at 0xA4000000 and 0xA4000040, awlen=15, wlast on words 15 and 31, wr_addr=0xA4000080.
REQ-030 RING_BYTES=128, 48 words -> third burst at 0xA4000000, wrapped=1 after second B.
REQ-031 enable dropped after beat 5 of a burst -> remaining 10 beats and the B response complete, then busy=0 and no new awvalid.
REQ-032 Slave returns bresp=2'b10 on the first burst -> err=1; the second burst proceeds normally; err stays 1.
REQ-033 aresetn=0 at beat 8 with awready/wready random -> next cycle all outputs at reset values, wr_addr=0xA4000000.
